// File: rtl/zpg_pkg.sv
// Shared definitions for the zero_pattern_gen serial frame transmitter:
// FSM state encoding and a frame-length helper.
package zpg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PRE  = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_PAR  = 3'd3;
  localparam state_t ST_STOP = 3'd4;

  // Number of busy cycles in one frame: preamble + data + optional parity + stop.
  function automatic int frame_len(input int pre_len, input int data_w, input bit par_en);
    return pre_len + data_w + (par_en ? 1 : 0) + 1;
  endfunction

endpackage

// File: rtl/zpg_shift_reg.sv
// Parallel-load, shift-left register with synchronous clear; the MSB is the
// serial tap so data leaves MSB-first.
module zpg_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (clear) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/zero_pattern_gen.sv
// Serial framed-pattern transmitter: preamble ones, data MSB-first, optional
// even-parity bit (build with PARITY_EN defined), then a single 0 stop bit.
module zero_pattern_gen
  import zpg_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRE_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              X
);

  localparam int CNT_MAX = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift;
  logic             msb;

  // Acceptance happens only from IDLE, so start/data_in during a frame are ignored.
  assign load  = (state == ST_IDLE) && start;
  assign shift = (state == ST_DATA);

  zpg_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk   (clk),
    .clear (!rst),
    .load  (load),
    .shift (shift),
    .din   (data_in),
    .msb   (msb)
  );

`ifdef PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= ^data_in;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_PRE;
            cnt   <= '0;
          end
        end
        ST_PRE: begin
          if (cnt == CNT_W'(PRE_LEN - 1)) begin
            state <= ST_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt <= '0;
`ifdef PARITY_EN
            state <= ST_PAR;
`else
            state <= ST_STOP;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef PARITY_EN
        ST_PAR: begin
          state <= ST_STOP;
          cnt   <= '0;
        end
`endif
        ST_STOP: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; nothing combinational from start/data_in.
  always_comb begin
    X = 1'b0;
    case (state)
      ST_PRE:  X = 1'b1;
      ST_DATA: X = msb;
`ifdef PARITY_EN
      ST_PAR:  X = par_bit;
`endif
      default: X = 1'b0;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_STOP);

endmodule

// File: tb/tb_zero_pattern_gen.sv
// Self-checking bench for zero_pattern_gen: a frame model fills an expected
// queue on every accepted start, and a monitor compares each busy cycle.
module tb_zero_pattern_gen;

  localparam int DATA_W  = 8;
  localparam int PRE_LEN = 2;
`ifdef PARITY_EN
  localparam int FLEN = PRE_LEN + DATA_W + 2;
`else
  localparam int FLEN = PRE_LEN + DATA_W + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              x_line;

  int total = 0;
  int bad   = 0;

  // Each entry is {done, X} expected for one busy cycle.
  logic [1:0] exp_q[$];
  int         model_rem = 0;

  zero_pattern_gen #(.DATA_W(DATA_W), .PRE_LEN(PRE_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .X       (x_line)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Frame built straight from the rules: ones, data MSB-first, parity, zero stop.
  always @(posedge clk) begin
    if (!rst) begin
      model_rem = 0;
      exp_q.delete();
    end else if (model_rem == 0) begin
      if (start) begin
        for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(2'b01);
        for (int i = 0; i < DATA_W; i++) exp_q.push_back({1'b0, data_in[DATA_W-1-i]});
`ifdef PARITY_EN
        exp_q.push_back({1'b0, ^data_in});
`endif
        exp_q.push_back(2'b10);
        model_rem = FLEN;
      end
    end else begin
      model_rem--;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [1:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      total++;
      if (busy !== (model_rem > 0)) begin
        bad++;
        $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, (model_rem > 0));
      end
      if (busy === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL frame_bit t=%0t actual={done,X}=%b%b required=no_frame", $time, done, x_line);
        end else begin
          e = exp_q.pop_front();
          if ({done, x_line} !== e) begin
            bad++;
            $display("FAIL frame_bit t=%0t actual={done,X}=%b%b required=%b", $time, done, x_line, e);
          end
        end
      end else begin
        total++;
        if ({done, x_line} !== 2'b00) begin
          bad++;
          $display("FAIL idle_out t=%0t actual={done,X}=%b%b required=00", $time, done, x_line);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((model_rem != 0 || busy !== 1'b0) && guard < 200) begin
      tick(1);
      guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL idle_timeout t=%0t actual=busy required=idle", $time);
    end
  endtask

  // Returns positioned in the first cycle of the new frame.
  task automatic pulse(input logic [DATA_W-1:0] d);
    start   = 1'b1;
    data_in = d;
    tick(1);
    start   = 1'b0;
    data_in = DATA_W'($urandom);
  endtask

  task automatic capture_check(input string name, input logic [FLEN-1:0] want);
    logic [FLEN-1:0] got;
    for (int i = FLEN - 1; i >= 0; i--) begin
      @(negedge clk);
      got[i] = x_line;
    end
    #1;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] d;
    // reset held with start asserted: nothing may be accepted
    rst   = 1'b0;
    start = 1'b1;
    data_in = 8'hA5;
    tick(2);
    start = 1'b0;
    rst   = 1'b1;
    tick(2);

    // single frame, exact waveform
    pulse(8'hA5);
`ifdef PARITY_EN
    capture_check("frame_a5", 12'b111010010100);
`else
    capture_check("frame_a5", 11'b11101001010);
`endif
    wait_idle();

`ifdef PARITY_EN
    tick(1);
    pulse(8'hA7);
    capture_check("frame_a7_par", 12'b111010011110);
    wait_idle();
`endif

    // start with new data during data bit 2 is ignored
    tick(1);
    pulse(8'hA5);
    tick(3);
    start   = 1'b1;
    data_in = 8'hFF;
    tick(1);
    start   = 1'b0;
    wait_idle();

    // reset during data bit 3 aborts the frame, then a clean frame
    tick(1);
    pulse(8'hC3);
    tick(4);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    pulse(8'h3C);
`ifdef PARITY_EN
    capture_check("frame_3c", 12'b110011110000);
`else
    capture_check("frame_3c", 11'b11001111000);
`endif
    wait_idle();

    // start held high: back-to-back frames with one idle cycle between
    start   = 1'b1;
    data_in = 8'h80;
    tick(3 * (FLEN + 1));
    start = 1'b0;
    wait_idle();

    // randomized frames, gaps, noise while busy, occasional aborts
    for (int n = 0; n < 40; n++) begin
      tick($urandom_range(0, 4));
      d = DATA_W'($urandom);
      start   = 1'b1;
      data_in = d;
      tick($urandom_range(1, 3));
      start = 1'b0;
      for (int c = 0; c < FLEN; c++) begin
        start   = ($urandom_range(0, 3) == 0);
        data_in = DATA_W'($urandom);
        if ($urandom_range(0, 40) == 0) rst = 1'b0;
        tick(1);
        rst = 1'b1;
      end
      start = 1'b0;
      wait_idle();
    end

    tick(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
